gray_to_rgb: RTL and testbench

//  Colorspace expander: the inverse-direction partner of the RGB->grayscale converter.
//  - Takes a grayscale pixel stream and rebuilds a P_PIXEL_DEPTH RGB pixel for display/debug output.
//  - Selectable mapping: replicate, inverted, binary threshold, or "jet" pseudocolor.
//  - 2-stage pipeline with valid/ready backpressure; sits between the edge-detect core and the pixel output.

---
 rtl/colorspace_pkg.sv | 18 +
 rtl/gray_to_rgb_if.sv | 27 ++
 rtl/jet_colormap.sv | 29 ++
 rtl/gray_to_rgb.sv | 75 +++++++
 tb/tb_gray_to_rgb.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/colorspace_pkg.sv
// Shared colorspace definitions: mapping-mode encodings, channel sizing, pipeline depth.
package colorspace_pkg;

    typedef enum logic [1:0] {
        MODE_REPLICATE = 2'b00,
        MODE_JET       = 2'b01,
        MODE_THRESH    = 2'b10,
        MODE_INVERT    = 2'b11
    } mode_e;

    localparam int GRAY2RGB_LATENCY = 2;

    // Per-channel width of a packed {R,G,B} pixel.
    function automatic int chan_depth(input int pixel_depth);
        return pixel_depth / 3;
    endfunction

endpackage

// File: rtl/gray_to_rgb_if.sv
// Pixel stream bus for gray_to_rgb: input pixel + sampled controls, output pixel, handshakes.
interface gray_to_rgb_if
    import colorspace_pkg::*;
#(
    parameter int P_PIXEL_DEPTH = 24
);
    localparam int C = chan_depth(P_PIXEL_DEPTH);

    logic                     I_ENABLE;
    logic [P_PIXEL_DEPTH-1:0] I_PIXEL;
    logic [1:0]               I_MODE;
    logic [C-1:0]             I_THRESHOLD;
    logic                     I_READY;
    logic                     O_READY;
    logic [P_PIXEL_DEPTH-1:0] O_PIXEL;
    logic                     O_DONE;

    modport master (
        output I_ENABLE, I_PIXEL, I_MODE, I_THRESHOLD, I_READY,
        input  O_READY, O_PIXEL, O_DONE
    );

    modport slave (
        input  I_ENABLE, I_PIXEL, I_MODE, I_THRESHOLD, I_READY,
        output O_READY, O_PIXEL, O_DONE
    );
endinterface

// File: rtl/jet_colormap.sv
// Combinational "jet" pseudocolor: luma -> {R,G,B}, four linear segments blue->cyan->green->yellow->red.
module jet_colormap #(
    parameter int C = 8
) (
    input  logic [C-1:0]   g,
    output logic [3*C-1:0] rgb
);
    localparam logic [C-1:0] MAX  = '1;
    localparam logic [C-1:0] ZERO = '0;

    logic [1:0]   seg;
    logic [C-1:0] f;

    // Top two bits pick the segment; the rest is stretched to full scale by
    // replicating its top bits into the LSBs so f reaches exactly MAX.
    assign seg = g[C-1:C-2];
    assign f   = {g[C-3:0], g[C-3:C-4]};

    // Segment ramp selection.
    always_comb begin
        rgb = '0;
        case (seg)
            2'd0:    rgb = {ZERO, f, MAX};
            2'd1:    rgb = {ZERO, MAX, MAX - f};
            2'd2:    rgb = {f, MAX, ZERO};
            default: rgb = {MAX, MAX - f, ZERO};
        endcase
    end
endmodule

// File: rtl/gray_to_rgb.sv
// Grayscale -> RGB expander: 2-stage valid/ready pipeline with per-pixel mapping mode.
module gray_to_rgb
    import colorspace_pkg::*;
#(
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic          I_CLK,
    input  logic          I_RESET,
    gray_to_rgb_if.slave  bus
);
    localparam int C = chan_depth(P_PIXEL_DEPTH);
    localparam logic [C-1:0] MAX = '1;

    logic [GRAY2RGB_LATENCY:1] vld_pipe;
    logic                      adv1, adv2;

    logic [C-1:0]             g_q, thr_q;
    mode_e                    mode_q;
    logic [P_PIXEL_DEPTH-1:0] pix_q;
    logic [P_PIXEL_DEPTH-1:0] mapped;
    logic [P_PIXEL_DEPTH-1:0] jet_rgb;
    logic [C-1:0]             thr_lvl;

    // A stage may load when it is empty or the stage after it is moving.
    assign adv2        = !vld_pipe[2] || bus.I_READY;
    assign adv1        = !vld_pipe[1] || adv2;
    assign bus.O_READY = adv1;
    assign bus.O_DONE  = vld_pipe[2];
    assign bus.O_PIXEL = pix_q;

    // Stage 1: capture luma with its own mode/threshold so later control changes don't touch it.
    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            vld_pipe[1] <= 1'b0;
            g_q         <= '0;
            thr_q       <= '0;
            mode_q      <= MODE_REPLICATE;
        end else if (adv1) begin
            vld_pipe[1] <= bus.I_ENABLE;
            g_q         <= bus.I_PIXEL[C-1:0];
            thr_q       <= bus.I_THRESHOLD;
            mode_q      <= mode_e'(bus.I_MODE);
        end
    end

    jet_colormap #(.C(C)) u_jet (
        .g   (g_q),
        .rgb (jet_rgb)
    );

    assign thr_lvl = (g_q >= thr_q) ? MAX : '0;

    // Mode mux feeding the output register.
    always_comb begin
        mapped = '0;
        case (mode_q)
            MODE_REPLICATE: mapped = {3{g_q}};
            MODE_JET:       mapped = jet_rgb;
            MODE_THRESH:    mapped = {3{thr_lvl}};
            MODE_INVERT:    mapped = {3{MAX - g_q}};
            default:        mapped = '0;
        endcase
    end

    // Stage 2: output register; holds while the consumer stalls.
    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            vld_pipe[2] <= 1'b0;
            pix_q       <= '0;
        end else if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            pix_q       <= mapped;
        end
    end
endmodule

// File: tb/tb_gray_to_rgb.sv
// Scoreboard bench for gray_to_rgb: directed corners, backpressure, async reset, random traffic.
module tb_gray_to_rgb;
    localparam int PD = 24;

    typedef struct {
        logic [PD-1:0] pix;
        int            cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    gray_to_rgb_if #(.P_PIXEL_DEPTH(PD)) bus ();

    gray_to_rgb #(.P_PIXEL_DEPTH(PD)) dut (
        .I_CLK   (clk),
        .I_RESET (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    exp_t sb[$];
    logic [PD-1:0] cur_exp;
    bit lat_chk;
    bit saw_ordy_low;
    bit rand_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model built straight from the mapping rules (8-bit channels).
    function automatic logic [PD-1:0] ref_rgb(input int g, input int m, input int thr);
        int r, gg, b, seg, f;
        r = 0; gg = 0; b = 0;
        case (m)
            0: begin r = g; gg = g; b = g; end
            3: begin r = 255 - g; gg = r; b = r; end
            2: begin r = (g >= thr) ? 255 : 0; gg = r; b = r; end
            default: begin
                seg = g / 64;
                f   = (g % 64) * 4 + (g % 64) / 16;
                case (seg)
                    0: begin r = 0;   gg = f;       b = 255;     end
                    1: begin r = 0;   gg = 255;     b = 255 - f; end
                    2: begin r = f;   gg = 255;     b = 0;       end
                    default: begin r = 255; gg = 255 - f; b = 0; end
                endcase
            end
        endcase
        return PD'(r * 65536 + gg * 256 + b);
    endfunction

    // Monitor: tracks occupancy, pushes on input transfer, pops/compares on output transfer.
    initial begin
        bit prev_stall;
        logic [PD-1:0] prev_pix;
        exp_t e;
        prev_stall = 0;
        prev_pix = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                prev_stall = 0;
                chk("reset_o_done", 32'(bus.O_DONE), 0);
                chk("reset_o_pixel", 32'(bus.O_PIXEL), 0);
            end else begin
                chk("o_ready", 32'(bus.O_READY), 32'((sb.size() < 2) || bus.I_READY));
                if (!bus.O_READY) saw_ordy_low = 1;
                if (sb.size() == 0) chk("no_spurious_done", 32'(bus.O_DONE), 0);
                if (bus.O_DONE && sb.size() != 0) begin
                    if (bus.I_READY) begin
                        e = sb.pop_front();
                        chk("pixel", 32'(bus.O_PIXEL), 32'(e.pix));
                        if (lat_chk) chk("latency", 32'(cyc - e.cyc), 2);
                        prev_stall = 0;
                    end else begin
                        if (prev_stall) chk("stall_stable", 32'(bus.O_PIXEL), 32'(prev_pix));
                        prev_stall = 1;
                        prev_pix = bus.O_PIXEL;
                    end
                end else begin
                    prev_stall = 0;
                end
                if (bus.I_ENABLE && bus.O_READY) begin
                    e.pix = cur_exp;
                    e.cyc = cyc;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] g, input logic [1:0] m, input logic [7:0] thr,
                        input logic [PD-1:0] exp_pix);
        bit ok;
        int tries;
        logic [15:0] hi;
        tries = 0;
        hi = 16'($urandom);
        bus.I_ENABLE    = 1'b1;
        bus.I_PIXEL     = {hi, g};
        bus.I_MODE      = m;
        bus.I_THRESHOLD = thr;
        cur_exp         = exp_pix;
        do begin
            @(negedge clk);
            ok = bus.O_READY;
            @(posedge clk);
            #1;
            tries++;
        end while (!ok && tries < 64);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: O_READY stayed 0 for %0d cycles", tries);
        end
    endtask

    task automatic idle();
        bus.I_ENABLE = 1'b0;
        bus.I_PIXEL  = PD'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_left", 32'(sb.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        bus.I_ENABLE = 1'b0;
        bus.I_PIXEL = '0;
        bus.I_MODE = 2'b00;
        bus.I_THRESHOLD = '0;
        bus.I_READY = 1'b1;
        cur_exp = '0;
        lat_chk = 1;
        saw_ordy_low = 0;
        rand_done = 0;

        // Reset held with enable asserted: nothing may come out.
        #2 rst_n = 1'b0;
        bus.I_ENABLE = 1'b1;
        bus.I_PIXEL = 24'h12_34_56;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold_done", 32'(bus.O_DONE), 0);
        bus.I_ENABLE = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Replicate / invert.
        send(8'h5A, 2'b00, 8'h00, 24'h5A5A5A);
        send(8'h5A, 2'b11, 8'h00, 24'hA5A5A5);
        // Threshold, including thr=0.
        send(8'h7F, 2'b10, 8'h80, 24'h000000);
        send(8'h80, 2'b10, 8'h80, 24'hFFFFFF);
        send(8'h00, 2'b10, 8'h00, 24'hFFFFFF);
        // Jet corners.
        send(8'h00, 2'b01, 8'h00, 24'h0000FF);
        send(8'h3F, 2'b01, 8'h00, 24'h00FFFF);
        send(8'h40, 2'b01, 8'h00, 24'h00FFFF);
        send(8'h80, 2'b01, 8'h00, 24'h00FF00);
        send(8'hC0, 2'b01, 8'h00, 24'hFFFF00);
        send(8'hFF, 2'b01, 8'h00, 24'hFF0000);
        idle();
        drain();

        // Backpressure: g=1..8 back-to-back, consumer stalls for four cycles.
        lat_chk = 0;
        saw_ordy_low = 0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(8'(i), 2'b00, 8'h00, ref_rgb(i, 0, 0));
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.I_READY = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.I_READY = 1'b1;
            end
        join
        drain();
        chk("bp_oready_dropped", 32'(saw_ordy_low), 1);

        // Reset with two pixels in flight: both dropped.
        lat_chk = 1;
        send(8'h11, 2'b00, 8'h00, 24'h111111);
        send(8'h22, 2'b00, 8'h00, 24'h222222);
        idle();
        chk("midrst_pre_done", 32'(bus.O_DONE), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_async_done", 32'(bus.O_DONE), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Random traffic with random consumer stalls and random modes.
        lat_chk = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int g, m, t;
                    g = $urandom_range(0, 255);
                    m = $urandom_range(0, 3);
                    t = $urandom_range(0, 255);
                    send(8'(g), 2'(m), 8'(t), ref_rgb(g, m, t));
                    if ($urandom_range(0, 9) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus.I_READY = ($urandom_range(0, 9) < 7);
                end
                bus.I_READY = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
